// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus bundle: display scan-out, processor write stream and
// the single-port framebuffer. The slave modport is the arbiter's own view.
interface fb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);
  logic              disp_req;
  logic [9:0]        disp_x;
  logic [9:0]        disp_y;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_color;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_x, disp_y, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_valid, disp_color, wr_ready, wr_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, disp_x, disp_y, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_valid, disp_color, wr_ready, wr_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads win every slot, processor writes
// drain from a 4-entry FIFO otherwise. FB_ARBITER_STATS_EN adds the stall_cnt port.
module fb_arbiter #(
  parameter int                H_ACTIVE = 640,
  parameter int                V_ACTIVE = 480,
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 19,
  parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
  input  logic        clk,
  input  logic        reset,
  fb_arbiter_if.slave bus
`ifdef FB_ARBITER_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned NPIX   = H_ACTIVE * V_ACTIVE;
  localparam int          STAGES = 2;
  localparam int          DEPTH  = 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t            state, state_nx;
  logic [STAGES-1:0] vld_pipe, inb_pipe;
  logic              in_bounds;
  logic [ADDR_W-1:0] rd_addr;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [1:0]        wptr, rptr;
  logic [2:0]        count;
  logic              full, empty, push, pop, head_bad;

  logic [ADDR_W-1:0] mem_addr_q, addr_nx;
  logic [DATA_W-1:0] mem_wdata_q, wdata_nx;
  logic              disp_valid_q, wr_err_q;
  logic [DATA_W-1:0] disp_color_q;

  assign in_bounds = bus.disp_req
                   && (32'(bus.disp_x) < 32'(H_ACTIVE))
                   && (32'(bus.disp_y) < 32'(V_ACTIVE));
  assign rd_addr   = ADDR_W'(bus.disp_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(bus.disp_x);

  assign full     = (count == 3'(DEPTH));
  assign empty    = (count == 3'd0);
  assign push     = bus.wr_valid && !full;
  assign head_bad = (32'(fifo_addr[rptr]) >= NPIX);

  // A bad head entry is consumed in a slot that behaves like IDLE on the port.
  always_comb begin
    state_nx = S_IDLE;
    addr_nx  = mem_addr_q;
    wdata_nx = mem_wdata_q;
    pop      = 1'b0;
    if (in_bounds) begin
      state_nx = S_READ;
      addr_nx  = rd_addr;
    end else if (!empty) begin
      pop = 1'b1;
      if (!head_bad) begin
        state_nx = S_WRITE;
        addr_nx  = fifo_addr[rptr];
        wdata_nx = fifo_data[rptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_err_q     <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      vld_pipe     <= '0;
      inb_pipe     <= '0;
      disp_valid_q <= 1'b0;
      disp_color_q <= '0;
    end else begin
      state       <= state_nx;
      mem_addr_q  <= addr_nx;
      mem_wdata_q <= wdata_nx;
      if (pop && head_bad) wr_err_q <= 1'b1;
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      count    <= count + {2'b0, push} - {2'b0, pop};
      vld_pipe <= {vld_pipe[STAGES-2:0], bus.disp_req};
      inb_pipe <= {inb_pipe[STAGES-2:0], in_bounds};
      disp_valid_q <= vld_pipe[STAGES-1];
      // mem_rdata for the read issued two edges ago is on the bus now.
      if (vld_pipe[STAGES-1])
        disp_color_q <= inb_pipe[STAGES-1] ? bus.mem_rdata : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= bus.wr_addr;
      fifo_data[wptr] <= bus.wr_data;
    end
  end

`ifdef FB_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (bus.wr_valid && full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign bus.mem_we     = (state == S_WRITE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.wr_ready   = !full;
  assign bus.wr_err     = wr_err_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_color = disp_color_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: slot-level model of the shared port (read, FIFO pop or
// idle each edge) checked every cycle, plus directed literal checks.
module tb_fb_arbiter;
  localparam int          H    = 640;
  localparam int          V    = 480;
  localparam int unsigned NPIX = H * V;
  localparam logic [7:0]  BG   = 8'hC3;

  logic clk, reset;
  fb_arbiter_if #(.DATA_W(8), .ADDR_W(19)) bus();
`ifdef FB_ARBITER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(8), .ADDR_W(19), .BG_COLOR(BG)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
`ifdef FB_ARBITER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Framebuffer RAM with one-cycle read latency; pl_* preloads before traffic.
  bit [7:0]  ram [0:524287];
  logic      pl_we;
  logic [18:0] pl_a;
  logic [7:0]  pl_d;
  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Model: each edge is exactly one port slot.
  typedef struct { int unsigned a; logic [7:0] d; } wr_t;
  wr_t         q[$];
  bit [7:0]    mm [0:524287];
  bit          e1v, e2v, exp_v, m_err, m_we;
  logic [7:0]  e1c, e2c, exp_c, last_wd;
  int unsigned last_addr;
  int unsigned m_stall;

  always @(posedge clk) begin
    int unsigned sz;
    bit inb;
    wr_t ent;
    if (pl_we) mm[pl_a] = pl_d;
    if (reset) begin
      q.delete();
      e1v = 0; e2v = 0; exp_v = 0; exp_c = 0; m_err = 0; m_we = 0;
      last_addr = 0; last_wd = 0; m_stall = 0;
    end else begin
      sz  = q.size();
      inb = bus.disp_req && (int'(bus.disp_x) < H) && (int'(bus.disp_y) < V);
      if (bus.wr_valid && sz >= 4 && m_stall < 32'hFFFF) m_stall++;
      exp_v = e2v;
      if (e2v) exp_c = e2c;
      e2v = e1v; e2c = e1c;
      e1v = bus.disp_req;
      e1c = inb ? mm[int'(bus.disp_y) * H + int'(bus.disp_x)] : BG;
      m_we = 0;
      if (inb) begin
        last_addr = int'(bus.disp_y) * H + int'(bus.disp_x);
      end else if (sz > 0) begin
        ent = q.pop_front();
        if (ent.a >= NPIX) m_err = 1;
        else begin
          m_we = 1; last_addr = ent.a; last_wd = ent.d; mm[ent.a] = ent.d;
        end
      end
      if (bus.wr_valid && sz < 4) q.push_back('{a: int'(bus.wr_addr), d: bus.wr_data});
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("disp_valid", 32'(bus.disp_valid), 32'(exp_v));
      chk("disp_color", 32'(bus.disp_color), 32'(exp_c));
      chk("wr_ready",   32'(bus.wr_ready),   32'(q.size() < 4));
      chk("wr_err",     32'(bus.wr_err),     32'(m_err));
      chk("mem_we",     32'(bus.mem_we),     32'(m_we));
      chk("mem_addr",   32'(bus.mem_addr),   last_addr);
      chk("mem_wdata",  32'(bus.mem_wdata),  32'(last_wd));
`ifdef FB_ARBITER_STATS_EN
      chk("stall_cnt",  32'(stall_cnt),      m_stall);
`endif
    end
  end

  task automatic push(input logic [18:0] a, input logic [7:0] d);
    int n = 0;
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    while (!bus.wr_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("push_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic read1(input int x, input int y);
    bus.disp_req = 1'b1; bus.disp_x = 10'(x); bus.disp_y = 10'(y);
    @(negedge clk);
    bus.disp_req = 1'b0;
  endtask

  initial begin
    int acc;
    bit rel;
    reset = 1'b1;
    bus.disp_req = 0; bus.disp_x = 0; bus.disp_y = 0;
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
    pl_we = 1'b1; pl_a = 19'd641; pl_d = 8'h5A;
    @(negedge clk);
    pl_we = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("rst_wr_ready",   32'(bus.wr_ready),   32'd1);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_wr_err",     32'(bus.wr_err),     32'd0);
    reset = 1'b0;
    @(negedge clk);

    // In-bounds read of preloaded address 641
    read1(1, 1);
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'd641);
    chk("rd_mem_we",   32'(bus.mem_we),   32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rd_valid", 32'(bus.disp_valid), 32'd1);
    chk("rd_color", 32'(bus.disp_color), 32'h5A);

    // Out-of-bounds request frees the slot for a pending write
    bus.disp_req = 1; bus.disp_x = 10'd2; bus.disp_y = 10'd0;
    bus.wr_valid = 1; bus.wr_addr = 19'd100; bus.wr_data = 8'h33;
    @(negedge clk);
    bus.wr_valid = 0; bus.disp_x = 10'd700; bus.disp_y = 10'd10;
    @(negedge clk);
    bus.disp_req = 0;
    chk("oob_mem_we",    32'(bus.mem_we),    32'd1);
    chk("oob_mem_addr",  32'(bus.mem_addr),  32'd100);
    chk("oob_mem_wdata", 32'(bus.mem_wdata), 32'h33);
    @(negedge clk);
    @(negedge clk);
    chk("oob_valid", 32'(bus.disp_valid), 32'd1);
    chk("oob_color", 32'(bus.disp_color), 32'(BG));

    // Continuous reads starve writes; FIFO fills at 4
    acc = 0;
    bus.disp_req = 1;
    for (int c = 0; c < 8; c++) begin
      bus.disp_x = 10'(c); bus.disp_y = 10'd2;
      bus.wr_valid = 1; bus.wr_addr = 19'(200 + acc); bus.wr_data = 8'(8'h40 + acc);
      if (bus.wr_ready) acc++;
      @(negedge clk);
    end
    chk("full_accepted", 32'(acc),          32'd4);
    chk("full_ready",    32'(bus.wr_ready), 32'd0);
    chk("full_mem_we",   32'(bus.mem_we),   32'd0);
    bus.disp_req = 0;
    rel = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_we",    32'(bus.mem_we),    32'd1);
      chk("drain_addr",  32'(bus.mem_addr),  32'(200 + i));
      chk("drain_wdata", 32'(bus.mem_wdata), 32'(8'h40 + i));
      if (rel) bus.wr_valid = 0;
      rel = bus.wr_valid && bus.wr_ready;
    end
    bus.wr_valid = 0;
    repeat (3) @(negedge clk);

    // Out-of-range write is dropped and flagged
    push(19'd307200, 8'h77);
    push(19'd5, 8'h11);
    repeat (4) @(negedge clk);
    chk("bad_wr_err", 32'(bus.wr_err), 32'd1);
    chk("ram5",       32'(ram[5]),     32'h11);
    read1(5, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rd5_color", 32'(bus.disp_color), 32'h11);
    for (int x = 200; x < 205; x++) begin
      bus.disp_req = 1; bus.disp_x = 10'(x); bus.disp_y = 10'd0;
      @(negedge clk);
    end
    bus.disp_req = 0;
    repeat (3) @(negedge clk);

    // Reset with buffered writes and reads in flight
    bus.disp_req = 1; bus.disp_x = 10'd9; bus.disp_y = 10'd3;
    push(19'd300, 8'hA0);
    push(19'd301, 8'hA1);
    push(19'd302, 8'hA2);
    reset = 1; bus.disp_req = 0;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.disp_valid), 32'd0);
      chk("post_rst_we",    32'(bus.mem_we),     32'd0);
      chk("post_rst_ready", 32'(bus.wr_ready),   32'd1);
    end

    // Mixed traffic, model-checked
    for (int c = 0; c < 40; c++) begin
      bus.disp_req = (c % 3 != 0);
      bus.disp_x   = 10'((c * 97) % 700);
      bus.disp_y   = 10'((c * 53) % 520);
      bus.wr_valid = (c % 2 == 0);
      bus.wr_addr  = (c == 12) ? 19'd400000 : 19'((c * 7919) % 300000);
      bus.wr_data  = 8'(c * 13 + 1);
      @(negedge clk);
    end
    bus.disp_req = 0; bus.wr_valid = 0;
    repeat (8) @(negedge clk);

`ifdef FB_ARBITER_STATS_EN
    reset = 1;
    @(negedge clk);
    reset = 0;
    bus.disp_req = 1; bus.disp_x = 0; bus.disp_y = 0;
    bus.wr_valid = 1; bus.wr_addr = 19'd7; bus.wr_data = 8'h01;
    repeat (14) @(negedge clk);
    chk("stall_10", 32'(stall_cnt), 32'd10);
    repeat (70000) @(negedge clk);
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    bus.disp_req = 0; bus.wr_valid = 0;
    repeat (8) @(negedge clk);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
